// File: rtl/fila_pkg.sv
// fila_pkg: shared defaults and status decode for the circular FIFO
package fila_pkg;
  localparam int FILA_WIDTH_DEF = 8;
  localparam int FILA_DEPTH_DEF = 8;
  typedef enum logic [1:0] {FILA_OK, FILA_OVF, FILA_UNF} fila_status_e;
  function automatic fila_status_e fila_status(input logic ovf, input logic unf);
    return ovf ? FILA_OVF : unf ? FILA_UNF : FILA_OK;
  endfunction
endpackage

// File: rtl/fila_circular_if.sv
// fila_circular_if: producer/consumer side signals of the circular FIFO
interface fila_circular_if
  import fila_pkg::*;
#(
  parameter int WIDTH = FILA_WIDTH_DEF,
  parameter int DEPTH = FILA_DEPTH_DEF
);
  localparam int LW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] data_in;
  logic             enqueue_in;
  logic             dequeue_in;
  logic             clear_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic [LW-1:0]    len_out;
  logic             full_out;
  logic             empty_out;
  logic             overflow_out;
  logic             underflow_out;
  modport master (
    output data_in, enqueue_in, dequeue_in, clear_in,
    input  data_out, valid_out, len_out, full_out, empty_out, overflow_out, underflow_out
  );
  modport slave (
    input  data_in, enqueue_in, dequeue_in, clear_in,
    output data_out, valid_out, len_out, full_out, empty_out, overflow_out, underflow_out
  );
endinterface

// File: rtl/fila_mem.sv
// fila_mem: unreset register array, one synchronous write port, combinational read
module fila_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_10KHz,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_10KHz)
    if (we) mem_q[wa] <= wd;
  assign rd = mem_q[ra];
endmodule

// File: rtl/fila_circular.sv
// fila_circular: pointer-based circular FIFO with flush, occupancy flags and error pulses
module fila_circular
  import fila_pkg::*;
#(
  parameter int WIDTH = FILA_WIDTH_DEF,
  parameter int DEPTH = FILA_DEPTH_DEF
) (
  input logic clk_10KHz,
  input logic reset,
  fila_circular_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fila_circular: DEPTH must be a power of two >= 2");
  end
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d, rd_data;
  logic             valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic             enq_ok, deq_ok, clr, we;
  fila_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk_10KHz(clk_10KHz),
    .we(we),
    .wa(wr_ptr_q),
    .wd(bus.data_in),
    .ra(rd_ptr_q),
    .rd(rd_data)
  );
  // a dequeue frees a slot in the same cycle, so a full queue still accepts a paired enqueue
  always_comb begin
    clr      = bus.clear_in;
    deq_ok   = bus.dequeue_in && count_q != '0;
    enq_ok   = bus.enqueue_in && (count_q != LW'(DEPTH) || deq_ok);
    we       = enq_ok && !clr;
    wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(enq_ok);
    rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(deq_ok);
    count_d  = clr ? '0 : count_q + LW'(enq_ok) - LW'(deq_ok);
    data_d   = (!clr && deq_ok) ? rd_data : data_q;
    valid_d  = !clr && deq_ok;
    ovf_d    = !clr && bus.enqueue_in && !enq_ok;
    unf_d    = !clr && bus.dequeue_in && !deq_ok;
  end
  always_ff @(posedge clk_10KHz or posedge reset)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  assign bus.data_out      = data_q;
  assign bus.valid_out     = valid_q;
  assign bus.len_out       = count_q;
  assign bus.full_out      = count_q == LW'(DEPTH);
  assign bus.empty_out     = count_q == '0;
  assign bus.overflow_out  = ovf_q;
  assign bus.underflow_out = unf_q;
endmodule
